// File: rtl/td4_pkg.sv
// td4_pkg: definitions shared across the TD4 mother-board logic.
//   ADDR_W        : width of the CPU fetch address bus and of the breakpoint address
//   exec_state_t  : execution-controller state, encoded for direct display on LEDs
//   is_halted()   : true for the states in which the CPU is not progressing
package td4_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } exec_state_t;

  function automatic logic is_halted(input exec_state_t s);
    return (s == ST_IDLE) || (s == ST_BREAK);
  endfunction

endpackage

// File: rtl/debouncer.sv
// debouncer: conditions a raw, bouncy, asynchronous push button.
//   A 2-flop synchronizer feeds a stability counter. The accepted level only
//   changes after the synchronized input has disagreed with it for
//   DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
//   A one-cycle registered pulse marks each accepted rising edge.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous active-high reset
//   btn    in  raw button, asynchronous to clock
//   pulse  out one-cycle strobe on an accepted press
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic             pulse_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      // The mismatch that completes the run is itself the accepting cycle.
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      meta_q      <= btn;
      sync_q      <= meta_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // Edge detect one cycle after acceptance keeps the pulse fully registered.
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/exec_controller.sv
// exec_controller: sequences the TD4 CPU by issuing a one-cycle cpu_enable
// strobe that gates every CPU register update.
//   IDLE  : waiting; run switch starts RUN, a button press issues one STEP.
//   RUN   : one strobe every DIV_COUNT clocks, unless the fetch address hits
//           the enabled breakpoint, in which case the controller enters BREAK.
//   STEP  : the single strobe cycle of a manual step; always returns to IDLE.
//   BREAK : parked at the breakpoint; step executes one instruction, dropping
//           the run switch returns to IDLE.
// Ports:
//   clock       in  system clock (only clock)
//   reset       in  asynchronous active-high reset
//   run_req     in  run switch level, asynchronous
//   step_btn    in  raw step push button, asynchronous and bouncy
//   bp_enable   in  breakpoint enable
//   bp_address  in  breakpoint address [ADDR_W]
//   address     in  current CPU fetch address [ADDR_W]
//   cpu_enable  out one-cycle instruction commit strobe
//   state       out current state encoding [2]
//   halted      out high in IDLE and BREAK
//   bp_hit      out high in BREAK
module exec_controller
  import td4_pkg::*;
#(
  parameter int DIV_COUNT       = 12_000_000,
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_req,
  input  logic              step_btn,
  input  logic              bp_enable,
  input  logic [ADDR_W-1:0] bp_address,
  input  logic [ADDR_W-1:0] address,
  output logic              cpu_enable,
  output logic [1:0]        state,
  output logic              halted,
  output logic              bp_hit
);

  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  // Run switch synchronizer
  logic run_meta_q;
  logic run_sync_q;

  // Debounced step button edge
  logic step_pulse;

  // Controller state
  exec_state_t      state_q;
  exec_state_t      state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             bp_skip_q;
  logic             bp_skip_d;
  logic             cpu_enable_q;
  logic             cpu_enable_d;
  logic             halted_q;
  logic             bp_hit_q;
  logic             bp_match;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  // Address only changes after a strobe, so it is settled by terminal count.
  assign bp_match = bp_enable && (address == bp_address);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bp_skip_d    = bp_skip_q;
    cpu_enable_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        // Run has priority; a coincident button press is dropped.
        if (run_sync_q) begin
          state_d = ST_RUN;
        end else if (step_pulse) begin
          state_d      = ST_STEP;
          cpu_enable_d = 1'b1;
        end
      end

      ST_STEP: begin
        state_d = ST_IDLE;
      end

      ST_RUN: begin
        if (!run_sync_q) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          // bp_skip lets the instruction we last broke on run once.
          if (bp_match && !bp_skip_q) begin
            state_d   = ST_BREAK;
            bp_skip_d = 1'b1;
          end else begin
            cpu_enable_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_BREAK: begin
        if (!run_sync_q) begin
          state_d = ST_IDLE;
        end else if (step_pulse) begin
          state_d      = ST_STEP;
          cpu_enable_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase

    // Any executed instruction consumes the skip.
    if (cpu_enable_d) begin
      bp_skip_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_meta_q   <= 1'b0;
      run_sync_q   <= 1'b0;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      bp_skip_q    <= 1'b0;
      cpu_enable_q <= 1'b0;
      halted_q     <= 1'b1;
      bp_hit_q     <= 1'b0;
    end else begin
      run_meta_q   <= run_req;
      run_sync_q   <= run_meta_q;
      state_q      <= state_d;
      div_q        <= div_d;
      bp_skip_q    <= bp_skip_d;
      cpu_enable_q <= cpu_enable_d;
      halted_q     <= is_halted(state_d);
      bp_hit_q     <= (state_d == ST_BREAK);
    end
  end

  assign cpu_enable = cpu_enable_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_exec_controller.sv
module tb_exec_controller;
  import td4_pkg::*;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int NV  = 45;

  logic       clock = 1'b0;
  logic       reset;
  logic       run_req;
  logic       step_btn;
  logic       bp_enable;
  logic [3:0] bp_address;
  logic [3:0] address;
  logic       cpu_enable;
  logic [1:0] state;
  logic       halted;
  logic       bp_hit;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  logic last_en = 1'b0;

  typedef struct {
    logic       run;
    logic       btn;
    logic       en;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [NV];

  always #5 clock = ~clock;

  exec_controller #(
    .DIV_COUNT(DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run_req    (run_req),
    .step_btn   (step_btn),
    .bp_enable  (bp_enable),
    .bp_address (bp_address),
    .address    (address),
    .cpu_enable (cpu_enable),
    .state      (state),
    .halted     (halted),
    .bp_hit     (bp_hit)
  );

  // Minimal CPU model: program counter advances once per committed strobe.
  always @(posedge clock or posedge reset) begin
    if (reset) address <= 4'd0;
    else if (cpu_enable) address <= address + 4'd1;
  end

  always @(posedge clock) begin
    if (!reset && cpu_enable) strobes <= strobes + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; also guard strobe width.
  task automatic tick();
    @(posedge clock);
    #1;
    if (cpu_enable) check("strobe_single_cycle", {31'd0, last_en}, 32'd0);
    last_en = cpu_enable;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check(name, state, s);
  endtask

  task automatic wait_strobe(input int budget, input string name);
    int n = 0;
    while (cpu_enable !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, cpu_enable, 1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    run_req    = 1'b0;
    step_btn   = 1'b0;
    bp_enable  = 1'b0;
    bp_address = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic run_to_break(input string tag);
    int s0;
    bp_enable  = 1'b1;
    bp_address = 4'd5;
    s0 = strobes;
    run_req = 1'b1;
    wait_state(2'b11, 100, {tag, "_reach_break"});
    check({tag, "_strobes_before_break"}, strobes - s0, 5);
    check({tag, "_break_address"}, address, 5);
    check({tag, "_bp_hit"}, bp_hit, 1);
    check({tag, "_halted"}, halted, 1);
  endtask

  initial begin
    int s0;

    // Directed per-cycle vectors: free run then button bounce in IDLE.
    for (int i = 0; i < NV; i++) begin
      vecs[i].run = (i < 15);
      vecs[i].btn = 1'b0;
      vecs[i].en  = 1'b0;
      vecs[i].st  = (i >= 2 && i <= 16) ? 2'b01 : 2'b00;
    end
    vecs[6].en  = 1'b1;
    vecs[10].en = 1'b1;
    vecs[14].en = 1'b1;
    vecs[21].btn = 1'b1;                       // 1-cycle glitch
    vecs[24].btn = 1'b1;                       // 2-cycle glitch
    vecs[25].btn = 1'b1;
    for (int i = 29; i < 35; i++) vecs[i].btn = 1'b1;  // 6-cycle press
    vecs[35].en = 1'b1;
    vecs[35].st = 2'b10;

    // Reset state
    reset      = 1'b1;
    run_req    = 1'b0;
    step_btn   = 1'b0;
    bp_enable  = 1'b0;
    bp_address = 4'd0;
    tick();
    tick();
    check("reset_state", state, 0);
    check("reset_halted", halted, 1);
    check("reset_bp_hit", bp_hit, 0);
    check("reset_cpu_enable", cpu_enable, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_req  = vecs[i].run;
      step_btn = vecs[i].btn;
      tick();
      check($sformatf("vec%0d_cpu_enable", i), cpu_enable, vecs[i].en);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      $display("vec %0d: run=%0b btn=%0b en=%0b state=%0d", i, vecs[i].run, vecs[i].btn, cpu_enable, state);
    end

    // Reset asserted while a RUN strobe is high kills it immediately.
    run_req = 1'b1;
    wait_strobe(20, "run_strobe_before_reset");
    reset   = 1'b1;
    run_req = 1'b0;
    #1;
    check("reset_kills_strobe", cpu_enable, 0);
    check("reset_mid_run_state", state, 0);
    check("reset_mid_run_halted", halted, 1);
    tick();
    reset = 1'b0;
    s0 = strobes;
    repeat (10) tick();
    check("no_strobe_after_reset", strobes - s0, 0);
    $display("reset mid-run: state=%0d strobes=%0d", state, strobes - s0);

    // Breakpoint at 5, then resume with a single step.
    run_to_break("bp");
    s0 = strobes;
    repeat (8) tick();
    check("bp_no_strobe_at_5", strobes - s0, 0);
    check("bp_stays_break", state, 3);
    step_btn = 1'b1;
    repeat (6) tick();
    step_btn = 1'b0;
    wait_strobe(10, "step_from_break_strobe");
    check("step_from_break_state", state, 2);
    s0 = strobes;
    tick();
    check("after_step_state_idle", state, 0);
    check("after_step_address", address, 6);
    check("after_step_bp_hit", bp_hit, 0);
    run_req = 1'b0;
    repeat (8) tick();
    check("after_step_no_extra", strobes - s0, 1);
    check("after_step_final_state", state, 0);
    check("after_step_final_address", address, 6);
    $display("step resume: address=%0d state=%0d", address, state);

    // Resume by toggling run: address 5 executes once, then breaks again at 5.
    do_reset();
    run_to_break("tog");
    run_req = 1'b0;
    wait_state(2'b00, 10, "tog_back_to_idle");
    repeat (3) tick();
    s0 = strobes;
    run_req = 1'b1;
    wait_strobe(20, "tog_first_strobe");
    check("tog_executes_addr5", address, 5);
    wait_state(2'b11, 200, "tog_break_again");
    check("tog_strobes_in_lap", strobes - s0, 16);
    check("tog_break_again_addr", address, 5);
    $display("toggle resume: strobes=%0d address=%0d", strobes - s0, address);

    // Simultaneous synchronized run rise and step pulse in IDLE.
    do_reset();
    step_btn = 1'b1;
    repeat (4) tick();
    run_req = 1'b1;
    repeat (3) tick();
    check("simul_state_run", state, 1);
    check("simul_no_step_strobe", cpu_enable, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("simul_cycle%0d_en", k), cpu_enable, (k == 4) ? 1 : 0);
      check($sformatf("simul_cycle%0d_state", k), state, 1);
    end
    $display("simultaneous: state=%0d en=%0b", state, cpu_enable);
    run_req  = 1'b0;
    step_btn = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
